// File: rtl/calc_pkg.sv
// Shared op codes, FSM/iteration encodings and op classification for the calculator core.
// CALC_SQRT_EN: when defined, op 5 (SQRT) is an iterative op; otherwise it is treated as illegal.
package calc_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_DIV  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_REM  = 4'd4;
    localparam logic [3:0] OP_SQRT = 4'd5;
    localparam logic [3:0] OP_CMP  = 4'd6;
    localparam logic [3:0] OP_SQA  = 4'd7;
    localparam logic [3:0] OP_SQB  = 4'd8;

    localparam logic [1:0] CMP_EQ = 2'd0;
    localparam logic [1:0] CMP_GT = 2'd1;
    localparam logic [1:0] CMP_LT = 2'd2;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
    typedef enum logic [1:0] {IT_MUL, IT_DIV, IT_SQRT} iter_mode_e;

    // Division by zero short-circuits to a single-cycle error result.
    function automatic logic op_is_iter(input logic [3:0] op, input logic b_zero);
        case (op)
            OP_MUL, OP_SQA, OP_SQB: return 1'b1;
            OP_DIV, OP_REM:         return !b_zero;
`ifdef CALC_SQRT_EN
            OP_SQRT:                return 1'b1;
`endif
            default:                return 1'b0;
        endcase
    endfunction

    function automatic iter_mode_e op_iter_mode(input logic [3:0] op);
        case (op)
            OP_DIV, OP_REM: return IT_DIV;
            OP_SQRT:        return IT_SQRT;
            default:        return IT_MUL;
        endcase
    endfunction

endpackage

// File: rtl/calc_iter_unit.sv
// WIDTH-step iterative datapath: shift-add multiplier plus a shift-subtract stage shared by the
// restoring divider and (with CALC_SQRT_EN defined) the bit-pair square root.
module calc_iter_unit
    import calc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  iter_mode_e           mode,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 last,
    output logic [2*WIDTH-1:0]   prod,
    output logic [WIDTH-1:0]     quot,
    output logic [WIDTH-1:0]     rem
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = WIDTH + 4;

    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] p, p_load;
    logic [WIDTH-1:0]   q;
    logic [WIDTH+1:0]   r, r_nx;
    logic [WIDTH:0]     mul_sum;
    logic [SW-1:0]      sh, tr, diff;
    logic               ge;

    assign mul_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? x : {WIDTH{1'b0}})};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sh     = {3'b000, r[WIDTH-1:0], q[WIDTH-1]};
        tr     = {4'b0000, y};
        p_load = {{WIDTH{1'b0}}, y};
`ifdef CALC_SQRT_EN
        // Root stage: bring down the next radicand bit pair, trial-subtract {root, 01}.
        if (mode == IT_SQRT) begin
            sh     = {r, p[2*WIDTH-1 -: 2]};
            tr     = {2'b00, q, 2'b01};
            p_load = {y, x};
        end
`endif
        diff = sh - tr;
        ge   = (sh >= tr);
        r_nx = ge ? diff[WIDTH+1:0] : sh[WIDTH+1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            p   <= '0;
            q   <= '0;
            r   <= '0;
        end else if (load) begin
            cnt <= CW'(WIDTH);
            p   <= p_load;
            q   <= (mode == IT_DIV) ? x : '0;
            r   <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            if (mode == IT_MUL) begin
                p <= {mul_sum, p[WIDTH-1:1]};
            end else begin
                q <= {q[WIDTH-2:0], ge};
                r <= r_nx;
`ifdef CALC_SQRT_EN
                if (mode == IT_SQRT) p <= p << 2;
`endif
            end
        end
    end

    assign last = (cnt == CW'(1));
    assign prod = p;
    assign quot = q;
    assign rem  = r[WIDTH-1:0];

endmodule

// File: rtl/calc_seq_core.sv
// Calculator core top: FSM, operand/result registers and single-cycle ops around calc_iter_unit.
// CALC_SQRT_EN: when defined, op 5 computes floor(sqrt({b,a})); otherwise it is an illegal op.
module calc_seq_core
    import calc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 err,
    output logic                 neg
);

    state_e             state, state_nx;
    logic [3:0]         op_q, op_sel;
    logic [WIDTH-1:0]   a_q, b_q, a_sel, b_sel, x_sel, y_sel;
    iter_mode_e         mode_sel;
    logic               accept, iter_sel, last;
    logic [2*WIDTH-1:0] prod, res_d;
    logic [WIDTH-1:0]   quot, remd;
    logic               err_d, neg_d;

    assign accept   = start && (state == ST_IDLE || state == ST_DONE);
    // The iterative unit loads on the accepting edge, before the operand registers update.
    assign op_sel   = accept ? op : op_q;
    assign a_sel    = accept ? a : a_q;
    assign b_sel    = accept ? b : b_q;
    assign iter_sel = op_is_iter(op_sel, b_sel == '0);

    always_comb begin
        mode_sel = op_iter_mode(op_sel);
        x_sel    = (op_sel == OP_SQB) ? b_sel : a_sel;
        y_sel    = (op_sel == OP_SQA) ? a_sel : b_sel;
    end

    calc_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk  (clk),
        .rst  (rst),
        .load (accept && iter_sel),
        .mode (mode_sel),
        .x    (x_sel),
        .y    (y_sel),
        .last (last),
        .prod (prod),
        .quot (quot),
        .rem  (remd)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE: state_nx = !start ? ST_IDLE : (iter_sel ? ST_RUN : ST_DONE);
            ST_RUN:           if (last) state_nx = ST_DONE;
            default:          state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        res_d = '0;
        err_d = 1'b0;
        neg_d = 1'b0;
        case (op_q)
            OP_ADD: res_d = {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};
            OP_SUB: begin
                res_d = {{WIDTH{1'b0}}, a_q} - {{WIDTH{1'b0}}, b_q};
                neg_d = (a_q < b_q);
            end
            OP_DIV: begin
                err_d = (b_q == '0);
                res_d = {{WIDTH{1'b0}}, (err_d ? {WIDTH{1'b1}} : quot)};
            end
            OP_REM: begin
                err_d = (b_q == '0);
                res_d = {{WIDTH{1'b0}}, (err_d ? a_q : remd)};
            end
            OP_MUL, OP_SQA, OP_SQB: res_d = prod;
`ifdef CALC_SQRT_EN
            OP_SQRT: res_d = {{WIDTH{1'b0}}, quot};
`endif
            OP_CMP: res_d = {{(2*WIDTH-2){1'b0}},
                             (a_q > b_q) ? CMP_GT : ((a_q < b_q) ? CMP_LT : CMP_EQ)};
            default: err_d = 1'b1;
        endcase
    end

    // Outputs register the finishing state, so done/result appear the cycle after DONE is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            err    <= 1'b0;
            neg    <= 1'b0;
        end else begin
            busy <= (state == ST_RUN);
            done <= (state == ST_DONE);
            if (accept) begin
                op_q <= op;
                a_q  <= a;
                b_q  <= b;
            end
            if (state == ST_DONE) begin
                result <= res_d;
                err    <= err_d;
                neg    <= neg_d;
            end else if (accept) begin
                err <= 1'b0;
                neg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_calc_seq_core.sv
// Self-checking bench for calc_seq_core (WIDTH=4): directed plan steps plus randomized ops
// checked against an arithmetic reference model.
module tb_calc_seq_core;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst, start;
    logic [3:0]     op;
    logic [W-1:0]   a, b;
    logic           busy, done, err, neg;
    logic [2*W-1:0] result;

    int checks   = 0;
    int failures = 0;

    calc_seq_core #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err),
        .neg    (neg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [3:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                                  output logic [2*W-1:0] r, output logic e, output logic n,
                                  output bit it);
        int ia = int'(va);
        int ib = int'(vb);
        int v  = 0;
        e  = 1'b0;
        n  = 1'b0;
        it = 1'b0;
        case (o)
            4'd0: v = ia + ib;
            4'd1: begin v = ia - ib; n = (ia < ib); end
            4'd2: if (ib == 0) begin v = (1 << W) - 1; e = 1'b1; end else begin v = ia / ib; it = 1'b1; end
            4'd3: begin v = ia * ib; it = 1'b1; end
            4'd4: if (ib == 0) begin v = ia; e = 1'b1; end else begin v = ia % ib; it = 1'b1; end
            4'd5: begin
`ifdef CALC_SQRT_EN
                int rad = ib * (1 << W) + ia;
                for (int s = 0; s < (1 << W); s++) if (s * s <= rad) v = s;
                it = 1'b1;
`else
                e = 1'b1;
`endif
            end
            4'd6: v = (ia > ib) ? 1 : ((ia < ib) ? 2 : 0);
            4'd7: begin v = ia * ia; it = 1'b1; end
            4'd8: begin v = ib * ib; it = 1'b1; end
            default: e = 1'b1;
        endcase
        r = v[2*W-1:0];
    endfunction

    // Issues one op from IDLE and checks timing, result and the hold cycle; poke pulses a stray
    // start mid-RUN that must be ignored. Operand inputs are scrambled after acceptance.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input bit poke);
        logic [2*W-1:0] er;
        logic ee, en;
        bit it;
        int lat;
        model(o, va, vb, er, ee, en, it);
        lat = it ? W + 1 : 1;
        op = o; a = va; b = vb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 4'($urandom); a = W'($urandom); b = W'($urandom);
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            check($sformatf("flags op%0d k%0d", o, k), {busy, done}, {(it && k <= W), (k == lat)});
            if (poke && it && k == 1) begin start = 1'b1; op = 4'd3; end
            if (k == 2) start = 1'b0;
        end
        check($sformatf("result op%0d a%0d b%0d", o, va, vb), result, er);
        check($sformatf("err_neg op%0d a%0d b%0d", o, va, vb), {err, neg}, {ee, en});
        @(posedge clk); #1;
        check($sformatf("hold op%0d", o), {busy, done, result}, {2'b00, er});
    endtask

    initial begin
        logic [2*W-1:0] er1, er2;
        logic ee, en;
        bit it;

        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", {busy, done}, 2'b00);
        check("reset_result", result, 0);
        check("reset_err_neg", {err, neg}, 2'b00);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(4'd0, 4'd9, 4'd7, 1'b0);
        run_op(4'd1, 4'd3, 4'd5, 1'b0);
        run_op(4'd3, 4'd15, 4'd15, 1'b1);
        run_op(4'd7, 4'd12, 4'd1, 1'b0);
        run_op(4'd2, 4'd13, 4'd4, 1'b0);
        run_op(4'd4, 4'd13, 4'd4, 1'b0);
        run_op(4'd2, 4'd13, 4'd0, 1'b0);
        run_op(4'd4, 4'd9, 4'd0, 1'b0);
        run_op(4'd5, 4'd8, 4'd12, 1'b0);
        run_op(4'd11, 4'd5, 4'd5, 1'b0);
        run_op(4'd6, 4'd4, 4'd9, 1'b0);
        run_op(4'd6, 4'd6, 4'd6, 1'b0);
        run_op(4'd8, 4'd3, 4'd11, 1'b0);

        // Reset in the middle of RUN, together with a start that must be dropped.
        op = 4'd3; a = 4'd7; b = 4'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1; start = 1'b1; op = 4'd0; a = 4'd1; b = 4'd1;
        @(posedge clk); #1;
        check("midrun_reset_flags", {busy, done}, 2'b00);
        check("midrun_reset_result", result, 0);
        check("midrun_reset_err_neg", {err, neg}, 2'b00);
        rst = 1'b0; start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("start_dropped_by_reset", {busy, done, result}, 0);
        run_op(4'd0, 4'd2, 4'd14, 1'b0);

        // Back-to-back: start held through DONE accepts the second op on that edge.
        model(4'd3, 4'd5, 4'd6, er1, ee, en, it);
        model(4'd0, 4'd2, 4'd3, er2, ee, en, it);
        op = 4'd3; a = 4'd5; b = 4'd6; start = 1'b1;
        @(posedge clk); #1;
        op = 4'd0; a = 4'd2; b = 4'd3;
        for (int k = 1; k <= W + 1; k++) begin
            @(posedge clk); #1;
            check($sformatf("b2b_flags k%0d", k), {busy, done}, {(k <= W), (k == W + 1)});
        end
        check("b2b_first_result", result, er1);
        start = 1'b0;
        @(posedge clk); #1;
        check("b2b_second_flags", {busy, done}, 2'b01);
        check("b2b_second_result", result, er2);
        @(posedge clk); #1;
        check("b2b_idle", {busy, done}, 2'b00);

        repeat (40) begin
            logic [3:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 4'($urandom_range(0, 15));
            ra = W'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
            run_op(ro, ra, rb, bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
